// File: rtl/display_write_arbiter_if.sv
// Requester handshakes and PIO write bus for display_write_arbiter.
// master = the arbiter, slave = requesters plus PIO register.
interface display_write_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              pio_chipselect;
    logic              pio_write_n;
    logic [1:0]        pio_address;
    logic [DATA_W-1:0] pio_writedata;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready,
        output pio_chipselect, pio_write_n, pio_address, pio_writedata
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready,
        input  pio_chipselect, pio_write_n, pio_address, pio_writedata
    );
endinterface

// File: rtl/display_write_arbiter.sv
// Two-requester round-robin arbiter for the display PIO register with a per-owner dwell.
// Define DISPLAY_ARB_PREEMPT_EN to let req0 preempt a HOLD owned by req1.
module display_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int DWELL_CYCLES = 16,
    parameter int CNT_W        = 26
) (
    input  logic                    clk,
    input  logic                    reset_n,
    display_write_arbiter_if.master bus,
    output logic                    owner,
    output logic                    owner_active,
    output logic [DATA_W-1:0]       cur_value
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic             HAS_DWELL  = (DWELL_CYCLES > 0);

    state_t            state;
    logic [CNT_W-1:0]  dwell_cnt;
    logic              last_grant;
    logic              owner_valid;
    logic              grant_en;
    logic              grant_idx;
    logic [DATA_W-1:0] grant_data;

    assign owner_valid     = owner ? bus.req1_valid : bus.req0_valid;
    assign grant_data      = grant_idx ? bus.req1_data : bus.req0_data;
    assign bus.pio_address = 2'b00;

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        grant_en  = 1'b0;
        grant_idx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    grant_en  = 1'b1;
                    grant_idx = ~last_grant;
                end else if (bus.req0_valid || bus.req1_valid) begin
                    grant_en  = 1'b1;
                    grant_idx = bus.req1_valid;
                end
            end
            ST_HOLD: begin
                // Only the current owner may rewrite while the display dwells.
                if (owner_valid) begin
                    grant_en  = 1'b1;
                    grant_idx = owner;
                end
`ifdef DISPLAY_ARB_PREEMPT_EN
                if (owner && bus.req0_valid) begin
                    grant_en  = 1'b1;
                    grant_idx = 1'b0;
                end
`endif
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            dwell_cnt          <= '0;
            last_grant         <= 1'b1;
            owner              <= 1'b0;
            owner_active       <= 1'b0;
            cur_value          <= '0;
            bus.pio_chipselect <= 1'b0;
            bus.pio_write_n    <= 1'b1;
            bus.pio_writedata  <= '0;
            bus.req0_ready     <= 1'b0;
            bus.req1_ready     <= 1'b0;
        end else begin
            bus.pio_chipselect <= 1'b0;
            bus.pio_write_n    <= 1'b1;
            bus.req0_ready     <= 1'b0;
            bus.req1_ready     <= 1'b0;

            if (grant_en) begin
                state              <= ST_WRITE;
                owner              <= grant_idx;
                owner_active       <= 1'b1;
                bus.pio_writedata  <= grant_data;
                bus.pio_chipselect <= 1'b1;
                bus.pio_write_n    <= 1'b0;
                bus.req0_ready     <= ~grant_idx;
                bus.req1_ready     <= grant_idx;
            end

            case (state)
                ST_WRITE: begin
                    cur_value    <= bus.pio_writedata;
                    last_grant   <= owner;
                    dwell_cnt    <= DWELL_LOAD;
                    state        <= HAS_DWELL ? ST_HOLD : ST_IDLE;
                    owner_active <= HAS_DWELL;
                end
                ST_HOLD: begin
                    if (dwell_cnt != '0)
                        dwell_cnt <= dwell_cnt - CNT_ONE;
                    if (!grant_en && dwell_cnt == CNT_ONE) begin
                        state        <= ST_IDLE;
                        owner_active <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_display_write_arbiter.sv
// Self-checking bench for display_write_arbiter with DWELL_CYCLES=4: vector table,
// directed corner sequences and a randomized run against a cycle-index reference model.
`timescale 1ns/1ps
module tb_display_write_arbiter;
    localparam int DATA_W = 32;
    localparam int DWELL  = 4;
    localparam int OUT_W  = 70;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              owner;
    logic              owner_active;
    logic [DATA_W-1:0] cur_value;

    display_write_arbiter_if #(.DATA_W(DATA_W)) bus ();

    display_write_arbiter #(
        .DATA_W      (DATA_W),
        .DWELL_CYCLES(DWELL),
        .CNT_W       (26)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .owner       (owner),
        .owner_active(owner_active),
        .cur_value   (cur_value)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc_n = 0;

    typedef struct {
        logic              v0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [DATA_W-1:0] d1;
        logic [OUT_W-1:0]  exp;
    } vec_t;

    vec_t tbl [14];

    // Reference model: remembers the cycle of the last write; HOLD is the DWELL cycles after it.
    int                m_w;
    logic              m_owner;
    logic              m_last;
    logic [DATA_W-1:0] m_wd;
    logic [DATA_W-1:0] m_cur;

    function automatic logic [OUT_W-1:0] pack(input logic cs, input logic wn, input logic [DATA_W-1:0] wd,
                                              input logic r0, input logic r1, input logic o, input logic a,
                                              input logic [DATA_W-1:0] cur);
        return {cs, wn, wd, r0, r1, o, a, cur};
    endfunction

    function automatic logic [OUT_W-1:0] observed();
        return pack(bus.pio_chipselect, bus.pio_write_n, bus.pio_writedata, bus.req0_ready,
                    bus.req1_ready, owner, owner_active, cur_value);
    endfunction

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic drive(input logic v0, input logic [DATA_W-1:0] d0, input logic v1, input logic [DATA_W-1:0] d1);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc_n   = 0;
    endtask

    task automatic wait_write(output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 40 && at < 0) begin
            cyc();
            n++;
            if (bus.pio_chipselect && !bus.pio_write_n)
                at = cyc_n;
        end
    endtask

    task automatic model_reset();
        m_w     = -1000;
        m_owner = 1'b0;
        m_last  = 1'b1;
        m_wd    = '0;
        m_cur   = '0;
    endtask

    // Called after edge cyc_n with the inputs that were present during cycle cyc_n-1.
    task automatic model_step(input logic v0, input logic [DATA_W-1:0] d0, input logic v1,
                              input logic [DATA_W-1:0] d1, output logic [OUT_W-1:0] exp);
        int   c;
        logic g;
        logic gi;
        logic wr;
        logic act;
        c  = cyc_n - 1;
        g  = 1'b0;
        gi = 1'b0;
        if (m_w == c) begin
            m_cur  = m_wd;
            m_last = m_owner;
        end else if (c > m_w && c <= m_w + DWELL) begin
            if (m_owner ? v1 : v0) begin
                g  = 1'b1;
                gi = m_owner;
            end
`ifdef DISPLAY_ARB_PREEMPT_EN
            if (m_owner && v0) begin
                g  = 1'b1;
                gi = 1'b0;
            end
`endif
        end else if (v0 || v1) begin
            g  = 1'b1;
            gi = (v0 && v1) ? !m_last : v1;
        end
        if (g) begin
            m_w     = cyc_n;
            m_owner = gi;
            m_wd    = gi ? d1 : d0;
        end
        wr  = (m_w == cyc_n);
        act = wr || (cyc_n > m_w && cyc_n <= m_w + DWELL);
        exp = pack(wr, !wr, m_wd, wr && !m_owner, wr && m_owner, m_owner, act, m_cur);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] a_v, b_v, c_v;
        logic              rv0, rv1;
        logic [DATA_W-1:0] rd0, rd1;
        logic [OUT_W-1:0]  e;
        int                t0, t1, t2, exp_gap;

        a_v = 32'h0000_1111;
        b_v = 32'h0000_2222;
        c_v = 32'h0000_3333;

        // Both requesters in IDLE, round-robin alternation with a 6-cycle spacing.
        tbl[0]  = '{1'b1, a_v, 1'b1, b_v, pack(1'b1, 1'b0, a_v, 1'b1, 1'b0, 1'b0, 1'b1, '0)};
        tbl[1]  = '{1'b0, a_v, 1'b1, b_v, pack(1'b0, 1'b1, a_v, 1'b0, 1'b0, 1'b0, 1'b1, a_v)};
        tbl[2]  = '{1'b0, '0,  1'b1, b_v, pack(1'b0, 1'b1, a_v, 1'b0, 1'b0, 1'b0, 1'b1, a_v)};
        tbl[3]  = '{1'b0, '0,  1'b1, b_v, pack(1'b0, 1'b1, a_v, 1'b0, 1'b0, 1'b0, 1'b1, a_v)};
        tbl[4]  = '{1'b0, '0,  1'b1, b_v, pack(1'b0, 1'b1, a_v, 1'b0, 1'b0, 1'b0, 1'b1, a_v)};
        tbl[5]  = '{1'b0, '0,  1'b1, b_v, pack(1'b0, 1'b1, a_v, 1'b0, 1'b0, 1'b0, 1'b0, a_v)};
        tbl[6]  = '{1'b0, '0,  1'b1, b_v, pack(1'b1, 1'b0, b_v, 1'b0, 1'b1, 1'b1, 1'b1, a_v)};
        tbl[7]  = '{1'b0, '0,  1'b0, '0,  pack(1'b0, 1'b1, b_v, 1'b0, 1'b0, 1'b1, 1'b1, b_v)};
        tbl[8]  = '{1'b0, '0,  1'b0, '0,  pack(1'b0, 1'b1, b_v, 1'b0, 1'b0, 1'b1, 1'b1, b_v)};
        tbl[9]  = '{1'b0, '0,  1'b0, '0,  pack(1'b0, 1'b1, b_v, 1'b0, 1'b0, 1'b1, 1'b1, b_v)};
        tbl[10] = '{1'b0, '0,  1'b0, '0,  pack(1'b0, 1'b1, b_v, 1'b0, 1'b0, 1'b1, 1'b1, b_v)};
        tbl[11] = '{1'b0, '0,  1'b0, '0,  pack(1'b0, 1'b1, b_v, 1'b0, 1'b0, 1'b1, 1'b0, b_v)};
        tbl[12] = '{1'b1, c_v, 1'b0, '0,  pack(1'b1, 1'b0, c_v, 1'b1, 1'b0, 1'b0, 1'b1, b_v)};
        tbl[13] = '{1'b0, '0,  1'b0, '0,  pack(1'b0, 1'b1, c_v, 1'b0, 1'b0, 1'b0, 1'b1, c_v)};

        drive(1'b0, '0, 1'b0, '0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", observed(), pack(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        check("reset_address", OUT_W'(bus.pio_address), '0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
            cyc();
            check($sformatf("tbl[%0d]", i), observed(), tbl[i].exp);
        end

        // Single write, then the non-owner arrives in the 2nd HOLD cycle and must stall.
        do_reset();
        drive(1'b1, 32'h0000_1234, 1'b0, '0);
        cyc();
        t0 = cyc_n;
        check("first_write", observed(), pack(1'b1, 1'b0, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b1, '0));
        drive(1'b0, '0, 1'b0, '0);
        cyc();
        check("after_first_write", observed(), pack(1'b0, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234));
        cyc();
        drive(1'b0, '0, 1'b1, 32'h0000_5555);
        wait_write(t1);
        check("stall_gap", OUT_W'(t1 - t0), OUT_W'(6));
        check("stall_grant", observed(), pack(1'b1, 1'b0, 32'h5555, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234));

        // Owner rewrite on the final HOLD cycle beats the waiting non-owner.
        do_reset();
        drive(1'b1, 32'h1111_0000, 1'b0, '0);
        wait_write(t0);
        check("idle_latency", OUT_W'(t0), OUT_W'(1));
        drive(1'b0, '0, 1'b1, 32'h0000_2222);
        repeat (4) cyc();
        drive(1'b1, 32'hAAAA_0000, 1'b1, 32'h0000_2222);
        wait_write(t1);
        check("rewrite_gap", OUT_W'(t1 - t0), OUT_W'(5));
        check("rewrite_grant", observed(), pack(1'b1, 1'b0, 32'hAAAA_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_0000));
        drive(1'b0, '0, 1'b1, 32'h0000_2222);
        wait_write(t2);
        check("after_rewrite_gap", OUT_W'(t2 - t1), OUT_W'(6));
        check("after_rewrite_grant", observed(), pack(1'b1, 1'b0, 32'h2222, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA_0000));

        // Asynchronous reset in the middle of a WRITE cycle.
        do_reset();
        drive(1'b1, 32'h0000_8888, 1'b0, '0);
        cyc();
        check("pre_reset_write", observed(), pack(1'b1, 1'b0, 32'h8888, 1'b1, 1'b0, 1'b0, 1'b1, '0));
        drive(1'b0, '0, 1'b1, 32'h0000_7777);
        #2 reset_n = 1'b0;
        #1;
        check("reset_mid_write", observed(), pack(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0));
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        check("post_reset_grant", observed(), pack(1'b1, 1'b0, 32'h7777, 1'b0, 1'b1, 1'b1, 1'b1, '0));

        // req0 arriving during a HOLD owned by req1.
        do_reset();
        drive(1'b0, '0, 1'b1, 32'h0000_4444);
        wait_write(t0);
        drive(1'b0, '0, 1'b0, '0);
        cyc();
        drive(1'b1, 32'h0000_00FF, 1'b0, '0);
        wait_write(t1);
`ifdef DISPLAY_ARB_PREEMPT_EN
        exp_gap = 2;
`else
        exp_gap = DWELL + 2;
`endif
        check("req0_vs_req1_hold_gap", OUT_W'(t1 - t0), OUT_W'(exp_gap));
        check("req0_vs_req1_hold_grant", observed(), pack(1'b1, 1'b0, 32'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4444));

        // Randomized requesters against the reference model.
        do_reset();
        model_reset();
        rv0 = 1'b0;
        rv1 = 1'b0;
        rd0 = '0;
        rd1 = '0;
        for (int i = 0; i < 3000; i++) begin
            if (bus.req0_ready) begin
                rv0 = ($urandom_range(3) == 0);
                rd0 = $urandom;
            end else if (rv0 && $urandom_range(15) == 0) begin
                rv0 = 1'b0;
            end else if (!rv0 && $urandom_range(2) == 0) begin
                rv0 = 1'b1;
                rd0 = $urandom;
            end
            if (bus.req1_ready) begin
                rv1 = ($urandom_range(3) == 0);
                rd1 = $urandom;
            end else if (rv1 && $urandom_range(15) == 0) begin
                rv1 = 1'b0;
            end else if (!rv1 && $urandom_range(2) == 0) begin
                rv1 = 1'b1;
                rd1 = $urandom;
            end
            drive(rv0, rd0, rv1, rd1);
            cyc();
            model_step(rv0, rd0, rv1, rd1, e);
            check($sformatf("rand[%0d]", i), observed(), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
